// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes and width helpers
// for the A-channel queue and its pointer counters.
package tl_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] ARITHMETIC_DATA  = 3'd2;
  localparam logic [2:0] LOGICAL_DATA     = 3'd3;
  localparam logic [2:0] GET              = 3'd4;
  localparam logic [2:0] INTENT           = 3'd5;
  localparam logic [2:0] ACQUIRE_BLOCK    = 3'd6;
  localparam logic [2:0] ACQUIRE_PERM     = 3'd7;

  // A single-entry queue still needs a 1-bit pointer to keep ports legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_wrap_counter.sv
// Modulo-N counter used for the queue's enqueue and dequeue pointers;
// N need not be a power of two.
module tl_wrap_counter
  import tl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inc,
  output logic [ptr_w(N)-1:0] value
);

  localparam int W = ptr_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/tl_a_queue.sv
// TileLink A-channel queue: DEPTH-entry in-order buffer of full A beats,
// with optional flow-through (empty bypass) and pipe (enq while full) modes.
module tl_a_queue
  import tl_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int FLOW     = 0,
  parameter int PIPE     = 0,
  parameter int SOURCE_W = 8,
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_enq_valid,
  output logic                      io_enq_ready,
  input  logic [2:0]                io_enq_bits_opcode,
  input  logic [2:0]                io_enq_bits_param,
  input  logic [SIZE_W-1:0]         io_enq_bits_size,
  input  logic [SOURCE_W-1:0]       io_enq_bits_source,
  input  logic [ADDR_W-1:0]         io_enq_bits_address,
  input  logic [DATA_W/8-1:0]       io_enq_bits_mask,
  input  logic [DATA_W-1:0]         io_enq_bits_data,
  input  logic                      io_enq_bits_corrupt,
  output logic                      io_deq_valid,
  input  logic                      io_deq_ready,
  output logic [2:0]                io_deq_bits_opcode,
  output logic [2:0]                io_deq_bits_param,
  output logic [SIZE_W-1:0]         io_deq_bits_size,
  output logic [SOURCE_W-1:0]       io_deq_bits_source,
  output logic [ADDR_W-1:0]         io_deq_bits_address,
  output logic [DATA_W/8-1:0]       io_deq_bits_mask,
  output logic [DATA_W-1:0]         io_deq_bits_data,
  output logic                      io_deq_bits_corrupt,
  output logic [count_w(DEPTH)-1:0] io_count
);

  localparam int   PTR_W   = ptr_w(DEPTH);
  localparam int   CNT_W   = count_w(DEPTH);
  localparam logic FLOW_EN = (FLOW != 0);
  localparam logic PIPE_EN = (PIPE != 0);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [SIZE_W-1:0]   size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } a_beat_t;

  a_beat_t          ram [DEPTH];
  a_beat_t          enq_beat;
  a_beat_t          head_beat;
  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;
  logic             ptr_match, empty, full;
  logic             do_enq, do_deq, flow_through;
  logic             enq_inc, deq_inc;

  assign enq_beat = '{
    opcode:  io_enq_bits_opcode,
    param:   io_enq_bits_param,
    size:    io_enq_bits_size,
    source:  io_enq_bits_source,
    address: io_enq_bits_address,
    mask:    io_enq_bits_mask,
    data:    io_enq_bits_data,
    corrupt: io_enq_bits_corrupt
  };

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  assign io_enq_ready = ~full | (PIPE_EN & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);

  assign do_enq = io_enq_valid & io_enq_ready;
  assign do_deq = io_deq_valid & io_deq_ready;

  // A bypassed beat goes straight through: no storage write, no pointer motion.
  assign flow_through = FLOW_EN & empty & do_deq;
  assign enq_inc      = do_enq & ~flow_through;
  assign deq_inc      = do_deq & ~flow_through;

  assign head_beat = (FLOW_EN && empty) ? enq_beat : ram[deq_ptr];

  assign io_deq_bits_opcode  = head_beat.opcode;
  assign io_deq_bits_param   = head_beat.param;
  assign io_deq_bits_size    = head_beat.size;
  assign io_deq_bits_source  = head_beat.source;
  assign io_deq_bits_address = head_beat.address;
  assign io_deq_bits_mask    = head_beat.mask;
  assign io_deq_bits_data    = head_beat.data;
  assign io_deq_bits_corrupt = head_beat.corrupt;

  tl_wrap_counter #(.N(DEPTH)) u_enq_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (enq_inc),
    .value (enq_ptr)
  );

  tl_wrap_counter #(.N(DEPTH)) u_deq_ptr (
    .clock (clock),
    .reset (reset),
    .inc   (deq_inc),
    .value (deq_ptr)
  );

  // NOTE: the beat storage is deliberately not reset; validity is tracked
  // entirely by the pointers and maybe_full, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (enq_inc) begin
      ram[enq_ptr] <= enq_beat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      maybe_full <= 1'b0;
    end else if (enq_inc != deq_inc) begin
      maybe_full <= enq_inc;
    end
  end

  logic [CNT_W-1:0] enq_wide, deq_wide;
  assign enq_wide = CNT_W'(enq_ptr);
  assign deq_wide = CNT_W'(deq_ptr);

  // NOTE: the output gets a default before the branches so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    io_count = '0;
    if (full) begin
      io_count = CNT_W'(DEPTH);
    end else if (enq_wide >= deq_wide) begin
      io_count = enq_wide - deq_wide;
    end else begin
      io_count = enq_wide + CNT_W'(DEPTH) - deq_wide;
    end
  end

endmodule

// File: tb/tb_tl_a_queue.sv
// Bench for tl_a_queue: four instances (DEPTH=2, DEPTH=3, FLOW, PIPE/DEPTH=1)
// share one stimulus bus; each sequence checks the instance it targets.
module tb_tl_a_queue;
  import tl_pkg::*;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic [2:0]  enq_opcode;
  logic [2:0]  enq_param;
  logic [3:0]  enq_size;
  logic [7:0]  enq_source;
  logic [13:0] enq_address;
  logic [7:0]  enq_mask;
  logic [63:0] enq_data;
  logic        enq_corrupt;
  logic        deq_ready;

  int compared   = 0;
  int mismatched = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int D = (g == 1) ? 3 : (g == 3) ? 1 : 2;
    logic                     enq_ready;
    logic                     deq_valid;
    logic [2:0]               opcode;
    logic [2:0]               param;
    logic [3:0]               size;
    logic [7:0]               source;
    logic [13:0]              address;
    logic [7:0]               mask;
    logic [63:0]              data;
    logic                     corrupt;
    logic [$clog2(D+1)-1:0]   count;

    tl_a_queue #(
      .DEPTH (D),
      .FLOW  ((g == 2) ? 1 : 0),
      .PIPE  ((g == 3) ? 1 : 0)
    ) u_dut (
      .clock               (clock),
      .reset               (reset),
      .io_enq_valid        (enq_valid),
      .io_enq_ready        (enq_ready),
      .io_enq_bits_opcode  (enq_opcode),
      .io_enq_bits_param   (enq_param),
      .io_enq_bits_size    (enq_size),
      .io_enq_bits_source  (enq_source),
      .io_enq_bits_address (enq_address),
      .io_enq_bits_mask    (enq_mask),
      .io_enq_bits_data    (enq_data),
      .io_enq_bits_corrupt (enq_corrupt),
      .io_deq_valid        (deq_valid),
      .io_deq_ready        (deq_ready),
      .io_deq_bits_opcode  (opcode),
      .io_deq_bits_param   (param),
      .io_deq_bits_size    (size),
      .io_deq_bits_source  (source),
      .io_deq_bits_address (address),
      .io_deq_bits_mask    (mask),
      .io_deq_bits_data    (data),
      .io_deq_bits_corrupt (corrupt),
      .io_count            (count)
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic ev, input logic [2:0] op, input logic [7:0] src,
                       input logic [3:0] sz, input logic [63:0] d, input logic dr);
    @(negedge clock);
    enq_valid   = ev;
    enq_opcode  = op;
    enq_param   = 3'd0;
    enq_size    = sz;
    enq_source  = src;
    enq_address = 14'h0100;
    enq_mask    = 8'hFF;
    enq_data    = d;
    enq_corrupt = 1'b0;
    deq_ready   = dr;
    #1;
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, PUT_FULL_DATA, 8'h00, 4'd0, 64'h0, dr);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        ev;
    logic [63:0] data;
    logic        dr;
    logic        exp_enq_ready;
    logic        exp_deq_valid;
    int          exp_count;
    logic        chk_data;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // DEPTH=3: fill with 4 offers while blocked, then drain; 0x44 enters as space opens.
    vecs[0] = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b0, 0, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 1, 1'b1, 64'h11};
    vecs[2] = '{1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 2, 1'b1, 64'h11};
    vecs[3] = '{1'b1, 64'h44, 1'b0, 1'b0, 1'b1, 3, 1'b1, 64'h11};
    vecs[4] = '{1'b1, 64'h44, 1'b0, 1'b0, 1'b1, 3, 1'b1, 64'h11};
    vecs[5] = '{1'b1, 64'h44, 1'b1, 1'b0, 1'b1, 3, 1'b1, 64'h11};
    vecs[6] = '{1'b1, 64'h44, 1'b1, 1'b1, 1'b1, 2, 1'b1, 64'h22};
    vecs[7] = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b1, 2, 1'b1, 64'h33};
    vecs[8] = '{1'b0, 64'h00, 1'b1, 1'b1, 1'b1, 1, 1'b1, 64'h44};
    vecs[9] = '{1'b0, 64'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 64'h0};

    reset = 1'b1;
    enq_valid = 1'b0;
    enq_opcode = 3'd0;
    enq_param = 3'd0;
    enq_size = 4'd0;
    enq_source = 8'd0;
    enq_address = 14'd0;
    enq_mask = 8'd0;
    enq_data = 64'd0;
    enq_corrupt = 1'b0;
    deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // DEPTH=2 reset state, then a Get beat one cycle later at deq.
    idle(1'b0);
    check("rst_enq_ready", 64'(gen_dut[0].enq_ready), 64'd1);
    check("rst_deq_valid", 64'(gen_dut[0].deq_valid), 64'd0);
    check("rst_count", 64'(gen_dut[0].count), 64'd0);
    drive(1'b1, GET, 8'h2A, 4'd3, 64'h0, 1'b0);
    check("get_not_bypassed", 64'(gen_dut[0].deq_valid), 64'd0);
    idle(1'b0);
    check("get_deq_valid", 64'(gen_dut[0].deq_valid), 64'd1);
    check("get_opcode", 64'(gen_dut[0].opcode), 64'd4);
    check("get_source", 64'(gen_dut[0].source), 64'h2A);
    check("get_size", 64'(gen_dut[0].size), 64'd3);

    // Table-driven fill/drain on DEPTH=3.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ev, PUT_FULL_DATA, 8'h01, 4'd3, vecs[i].data, vecs[i].dr);
      check($sformatf("vec%0d_enq_ready", i), 64'(gen_dut[1].enq_ready), 64'(vecs[i].exp_enq_ready));
      check($sformatf("vec%0d_deq_valid", i), 64'(gen_dut[1].deq_valid), 64'(vecs[i].exp_deq_valid));
      check($sformatf("vec%0d_count", i), 64'(gen_dut[1].count), 64'(vecs[i].exp_count));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_data", i), gen_dut[1].data, vecs[i].exp_data);
      end
    end

    // DEPTH=3 streaming of 10 beats: pointers wrap several times, count stays <= 1.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, PUT_FULL_DATA, 8'h02, 4'd3, 64'h100 + 64'(i), 1'b1);
      check($sformatf("stream%0d_count", i), 64'(gen_dut[1].count), (i == 0) ? 64'd0 : 64'd1);
      if (i == 0) begin
        check("stream0_deq_valid", 64'(gen_dut[1].deq_valid), 64'd0);
      end else begin
        check($sformatf("stream%0d_data", i), gen_dut[1].data, 64'h100 + 64'(i - 1));
      end
    end
    idle(1'b1);
    check("stream_last_valid", 64'(gen_dut[1].deq_valid), 64'd1);
    check("stream_last_data", gen_dut[1].data, 64'h109);
    idle(1'b1);
    check("stream_drained_count", 64'(gen_dut[1].count), 64'd0);
    check("stream_drained_valid", 64'(gen_dut[1].deq_valid), 64'd0);

    // FLOW: empty queue bypasses enq to deq in the same cycle without storing.
    do_reset();
    drive(1'b1, GET, 8'h07, 4'd2, 64'h0, 1'b1);
    check("flow_deq_valid", 64'(gen_dut[2].deq_valid), 64'd1);
    check("flow_source", 64'(gen_dut[2].source), 64'h07);
    check("flow_count", 64'(gen_dut[2].count), 64'd0);
    idle(1'b0);
    check("flow_after_valid", 64'(gen_dut[2].deq_valid), 64'd0);
    check("flow_after_count", 64'(gen_dut[2].count), 64'd0);
    drive(1'b1, GET, 8'h09, 4'd2, 64'h0, 1'b0);
    check("flow_held_valid", 64'(gen_dut[2].deq_valid), 64'd1);
    idle(1'b0);
    check("flow_held_count", 64'(gen_dut[2].count), 64'd1);
    check("flow_held_source", 64'(gen_dut[2].source), 64'h09);

    // PIPE, DEPTH=1: full queue accepts a new beat in the cycle the old one leaves.
    do_reset();
    drive(1'b1, PUT_FULL_DATA, 8'h03, 4'd3, 64'hA1, 1'b0);
    check("pipe_empty_ready", 64'(gen_dut[3].enq_ready), 64'd1);
    idle(1'b0);
    check("pipe_full_count", 64'(gen_dut[3].count), 64'd1);
    check("pipe_full_blocked", 64'(gen_dut[3].enq_ready), 64'd0);
    drive(1'b1, PUT_FULL_DATA, 8'h03, 4'd3, 64'hB2, 1'b1);
    check("pipe_swap_ready", 64'(gen_dut[3].enq_ready), 64'd1);
    check("pipe_swap_old_data", gen_dut[3].data, 64'hA1);
    idle(1'b0);
    check("pipe_swap_count", 64'(gen_dut[3].count), 64'd1);
    check("pipe_swap_new_data", gen_dut[3].data, 64'hB2);

    // Reset with two beats held on DEPTH=2 discards them.
    do_reset();
    drive(1'b1, PUT_FULL_DATA, 8'h04, 4'd3, 64'hC1, 1'b0);
    drive(1'b1, PUT_FULL_DATA, 8'h04, 4'd3, 64'hC2, 1'b0);
    idle(1'b0);
    check("held_count", 64'(gen_dut[0].count), 64'd2);
    check("held_enq_ready", 64'(gen_dut[0].enq_ready), 64'd0);
    do_reset();
    #1;
    check("post_rst_deq_valid", 64'(gen_dut[0].deq_valid), 64'd0);
    check("post_rst_count", 64'(gen_dut[0].count), 64'd0);
    check("post_rst_enq_ready", 64'(gen_dut[0].enq_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
